// File: rtl/board_state_ctrl.sv
// Minesweeper game-state writer: cursor/flag/step maps, loss on mine step, win via 64-cycle scan.
// Latency: every action lands at the next clock edge. Buttons are dropped while scanning or after game end.
module board_state_ctrl #(
    parameter bit WRAP       = 1'b1,
    parameter int START_TILE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mineMap,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_flag,
    input  logic        btn_step,
    output logic [63:0] flagMap,
    output logic [63:0] stepMap,
    output logic [63:0] posMap,
    output logic [5:0]  cursor,
    output logic        busy,
    output logic        game_won,
    output logic        game_lost
);

    localparam logic [5:0] START_POS = 6'(START_TILE);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_SCAN = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_flag_map;
    logic [63:0] r_step_map;
    logic [63:0] r_pos_map;
    logic [5:0]  r_cursor;
    logic        r_busy;
    logic        r_won;
    logic        r_lost;
    logic [5:0]  r_idx;
    logic        r_bad;

    logic [63:0] w_flag_nxt;
    logic [63:0] w_step_nxt;
    logic [63:0] w_pos_nxt;
    logic [5:0]  w_cursor_nxt;
    logic        w_busy_nxt;
    logic        w_won_nxt;
    logic        w_lost_nxt;
    logic [5:0]  w_idx_nxt;
    logic        w_bad_nxt;

    logic [2:0]  w_row;
    logic [2:0]  w_col;
    logic [2:0]  w_row_dec;
    logic [2:0]  w_row_inc;
    logic [2:0]  w_col_dec;
    logic [2:0]  w_col_inc;
    logic        w_step_ok;
    logic        w_tile_bad;
    logic        w_bad_acc;
    logic        w_scan_last;

    assign w_row = r_cursor[5:3];
    assign w_col = r_cursor[2:0];

    // 3-bit arithmetic wraps naturally; without WRAP the edge tile holds.
    assign w_row_dec = (WRAP || (w_row != 3'd0)) ? w_row - 3'd1 : w_row;
    assign w_row_inc = (WRAP || (w_row != 3'd7)) ? w_row + 3'd1 : w_row;
    assign w_col_dec = (WRAP || (w_col != 3'd0)) ? w_col - 3'd1 : w_col;
    assign w_col_inc = (WRAP || (w_col != 3'd7)) ? w_col + 3'd1 : w_col;

    assign w_step_ok   = btn_step & ~r_flag_map[r_cursor] & ~r_step_map[r_cursor];
    assign w_tile_bad  = ~(mineMap[r_idx] | r_step_map[r_idx]);
    assign w_bad_acc   = r_bad | w_tile_bad;
    assign w_scan_last = (r_idx == 6'd63);

    always_ff @(posedge clk) begin : p_state_reg
        if (!reset) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            ST_PLAY: begin
                if (w_step_ok) begin
                    w_state_nxt = mineMap[r_cursor] ? ST_LOST : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_scan_last) begin
                    w_state_nxt = w_bad_acc ? ST_PLAY : ST_WON;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin : p_outputs
        w_flag_nxt   = r_flag_map;
        w_step_nxt   = r_step_map;
        w_cursor_nxt = r_cursor;
        w_busy_nxt   = r_busy;
        w_won_nxt    = r_won;
        w_lost_nxt   = r_lost;
        w_idx_nxt    = r_idx;
        w_bad_nxt    = r_bad;
        case (r_state)
            ST_PLAY: begin
                // Single action per cycle; lower-priority pulses are discarded.
                if (btn_step) begin
                    if (w_step_ok) begin
                        if (mineMap[r_cursor]) begin
                            w_step_nxt = r_step_map | mineMap;
                            w_lost_nxt = 1'b1;
                        end else begin
                            w_step_nxt[r_cursor] = 1'b1;
                            w_busy_nxt           = 1'b1;
                            w_idx_nxt            = 6'd0;
                            w_bad_nxt            = 1'b0;
                        end
                    end
                end else if (btn_flag) begin
                    if (!r_step_map[r_cursor]) begin
                        w_flag_nxt[r_cursor] = ~r_flag_map[r_cursor];
                    end
                end else if (btn_up) begin
                    w_cursor_nxt = {w_row_dec, w_col};
                end else if (btn_down) begin
                    w_cursor_nxt = {w_row_inc, w_col};
                end else if (btn_left) begin
                    w_cursor_nxt = {w_row, w_col_dec};
                end else if (btn_right) begin
                    w_cursor_nxt = {w_row, w_col_inc};
                end
            end
            ST_SCAN: begin
                w_idx_nxt = r_idx + 6'd1;
                w_bad_nxt = w_bad_acc;
                if (w_scan_last) begin
                    w_busy_nxt = 1'b0;
                    w_won_nxt  = ~w_bad_acc;
                end
            end
            default: ;
        endcase
        w_pos_nxt = 64'd1 << w_cursor_nxt;
    end

    always_ff @(posedge clk) begin : p_data_reg
        if (!reset) begin
            r_flag_map <= 64'd0;
            r_step_map <= 64'd0;
            r_cursor   <= START_POS;
            r_pos_map  <= 64'd1 << START_POS;
            r_busy     <= 1'b0;
            r_won      <= 1'b0;
            r_lost     <= 1'b0;
            r_idx      <= 6'd0;
            r_bad      <= 1'b0;
        end else begin
            r_flag_map <= w_flag_nxt;
            r_step_map <= w_step_nxt;
            r_cursor   <= w_cursor_nxt;
            r_pos_map  <= w_pos_nxt;
            r_busy     <= w_busy_nxt;
            r_won      <= w_won_nxt;
            r_lost     <= w_lost_nxt;
            r_idx      <= w_idx_nxt;
            r_bad      <= w_bad_nxt;
        end
    end

    assign flagMap   = r_flag_map;
    assign stepMap   = r_step_map;
    assign posMap    = r_pos_map;
    assign cursor    = r_cursor;
    assign busy      = r_busy;
    assign game_won  = r_won;
    assign game_lost = r_lost;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Bench for board_state_ctrl: wrapping and holding instances driven in parallel against a tile-level game model.
module tb_board_state_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [63:0] mine_map;
    logic        b_up, b_down, b_left, b_right, b_flag, b_step;

    logic [63:0] d_flag [2];
    logic [63:0] d_step [2];
    logic [63:0] d_pos  [2];
    logic [5:0]  d_cur  [2];
    logic        d_busy [2];
    logic        d_won  [2];
    logic        d_lost [2];

    board_state_ctrl #(.WRAP(1'b1), .START_TILE(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .mineMap(mine_map),
        .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right),
        .btn_flag(b_flag), .btn_step(b_step),
        .flagMap(d_flag[0]), .stepMap(d_step[0]), .posMap(d_pos[0]), .cursor(d_cur[0]),
        .busy(d_busy[0]), .game_won(d_won[0]), .game_lost(d_lost[0])
    );

    board_state_ctrl #(.WRAP(1'b0), .START_TILE(0)) u_dut_hold (
        .clk(clk), .reset(reset), .mineMap(mine_map),
        .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right),
        .btn_flag(b_flag), .btn_step(b_step),
        .flagMap(d_flag[1]), .stepMap(d_step[1]), .posMap(d_pos[1]), .cursor(d_cur[1]),
        .busy(d_busy[1]), .game_won(d_won[1]), .game_lost(d_lost[1])
    );

    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_STEP  = 6'b100000;
    localparam logic [5:0] B_FLAG  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    int n_cmp = 0;
    int n_err = 0;

    // Game model: per-instance tile maps, row/col cursor, remaining scan cycles.
    logic [63:0] m_flag [2];
    logic [63:0] m_step [2];
    int          m_row  [2];
    int          m_col  [2];
    int          m_scan [2];
    bit          m_won  [2];
    bit          m_lost [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int t;
            t = m_row[k] * 8 + m_col[k];
            if (!reset) begin
                m_flag[k] = '0; m_step[k] = '0;
                m_row[k] = 0; m_col[k] = 0; m_scan[k] = 0;
                m_won[k] = 0; m_lost[k] = 0;
            end else if (m_won[k] || m_lost[k]) begin
            end else if (m_scan[k] > 0) begin
                m_scan[k]--;
                if (m_scan[k] == 0 && (&(mine_map | m_step[k]))) m_won[k] = 1;
            end else if (b_step) begin
                if (!m_flag[k][t] && !m_step[k][t]) begin
                    if (mine_map[t]) begin
                        m_step[k] = m_step[k] | mine_map;
                        m_lost[k] = 1;
                    end else begin
                        m_step[k][t] = 1'b1;
                        m_scan[k] = 64;
                    end
                end
            end else if (b_flag) begin
                if (!m_step[k][t]) m_flag[k][t] = ~m_flag[k][t];
            end else if (b_up) begin
                if (m_row[k] > 0) m_row[k]--; else if (k == 0) m_row[k] = 7;
            end else if (b_down) begin
                if (m_row[k] < 7) m_row[k]++; else if (k == 0) m_row[k] = 0;
            end else if (b_left) begin
                if (m_col[k] > 0) m_col[k]--; else if (k == 0) m_col[k] = 7;
            end else if (b_right) begin
                if (m_col[k] < 7) m_col[k]++; else if (k == 0) m_col[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int t;
            t = m_row[k] * 8 + m_col[k];
            chk($sformatf("flagMap%0d", k), d_flag[k], m_flag[k]);
            chk($sformatf("stepMap%0d", k), d_step[k], m_step[k]);
            chk($sformatf("posMap%0d", k), d_pos[k], 64'd1 << t);
            chk($sformatf("cursor%0d", k), 64'(d_cur[k]), 64'(t));
            chk($sformatf("busy%0d", k), 64'(d_busy[k]), 64'(m_scan[k] > 0));
            chk($sformatf("won%0d", k), 64'(d_won[k]), 64'(m_won[k]));
            chk($sformatf("lost%0d", k), 64'(d_lost[k]), 64'(m_lost[k]));
        end
    endtask

    task automatic cycle(input logic [5:0] btns, input logic rst_n);
        {b_step, b_flag, b_up, b_down, b_left, b_right} = btns;
        reset = rst_n;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        {b_step, b_flag, b_up, b_down, b_left, b_right} = B_NONE;
        reset = 1'b1;
    endtask

    task automatic do_reset(input logic [63:0] map);
        mine_map = map;
        cycle(B_NONE, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        mine_map = '0;
        {b_step, b_flag, b_up, b_down, b_left, b_right} = B_NONE;
        for (int k = 0; k < 2; k++) begin
            m_flag[k] = '0; m_step[k] = '0; m_row[k] = 0; m_col[k] = 0;
            m_scan[k] = 0; m_won[k] = 0; m_lost[k] = 0;
        end

        // Reset values
        do_reset(64'd0);
        chk("rst_pos", d_pos[0], 64'h1);
        chk("rst_cursor", 64'(d_cur[0]), 64'd0);
        chk("rst_flag", d_flag[0], 64'd0);
        chk("rst_step", d_step[0], 64'd0);
        chk("rst_flags3", {61'd0, d_busy[0], d_won[0], d_lost[0]}, 64'd0);

        // Edge wrap vs hold
        cycle(B_LEFT, 1'b1);
        chk("wrap_left_cur", 64'(d_cur[0]), 64'd7);
        chk("wrap_left_pos", d_pos[0], 64'h80);
        chk("hold_left_cur", 64'(d_cur[1]), 64'd0);
        cycle(B_UP, 1'b1);
        chk("wrap_up_cur", 64'(d_cur[0]), 64'd63);
        chk("hold_up_cur", 64'(d_cur[1]), 64'd0);

        // Flag toggles and blocks a step
        do_reset(64'd0);
        cycle(B_DOWN, 1'b1);
        cycle(B_RIGHT, 1'b1);
        chk("move_to_9", 64'(d_cur[0]), 64'd9);
        cycle(B_FLAG, 1'b1);
        chk("flag_set", d_flag[0], 64'h200);
        cycle(B_STEP, 1'b1);
        chk("flagged_step_map", d_step[0], 64'd0);
        chk("flagged_step_busy", 64'(d_busy[0]), 64'd0);
        cycle(B_FLAG, 1'b1);
        chk("flag_clear", d_flag[0], 64'd0);

        // Loss reveals all mines and freezes the game
        do_reset(64'h8000_0000_0000_0001);
        cycle(B_STEP, 1'b1);
        chk("lost_flag", 64'(d_lost[0]), 64'd1);
        chk("lost_step", d_step[0], 64'h8000_0000_0000_0001);
        cycle(B_RIGHT, 1'b1);
        cycle(B_STEP, 1'b1);
        cycle(B_FLAG, 1'b1);
        chk("lost_frozen_cur", 64'(d_cur[0]), 64'd0);
        chk("lost_frozen_step", d_step[0], 64'h8000_0000_0000_0001);
        chk("lost_frozen_flag", d_flag[0], 64'd0);

        // Win scan timing: busy for exactly 64 cycles
        do_reset(~64'h1);
        cycle(B_STEP, 1'b1);
        chk("scan_busy_first", 64'(d_busy[0]), 64'd1);
        for (int i = 1; i < 64; i++) begin
            cycle(B_RIGHT, 1'b1);
            chk("scan_busy", 64'(d_busy[0]), 64'd1);
            chk("scan_no_won", 64'(d_won[0]), 64'd0);
        end
        cycle(B_NONE, 1'b1);
        chk("scan_done_busy", 64'(d_busy[0]), 64'd0);
        chk("scan_won", 64'(d_won[0]), 64'd1);
        cycle(B_RIGHT, 1'b1);
        chk("won_frozen_cur", 64'(d_cur[0]), 64'd0);

        // Priority and reset during scan
        do_reset(64'h8000_0000_0000_0000);
        cycle(B_STEP | B_RIGHT, 1'b1);
        chk("prio_cur", 64'(d_cur[0]), 64'd0);
        chk("prio_step", d_step[0], 64'h1);
        chk("prio_busy", 64'(d_busy[0]), 64'd1);
        for (int i = 0; i < 9; i++) cycle(B_NONE, 1'b1);
        cycle(B_NONE, 1'b0);
        chk("midscan_rst_busy", 64'(d_busy[0]), 64'd0);
        chk("midscan_rst_step", d_step[0], 64'd0);
        cycle(B_RIGHT, 1'b1);
        chk("midscan_rst_play", 64'(d_cur[0]), 64'd1);

        // Randomized games
        for (int ep = 0; ep < 40; ep++) begin
            logic [63:0] mm;
            if (ep % 4 == 3) begin
                mm = ~(64'd1 << $urandom_range(0, 63)) & ~64'h1;
            end else begin
                mm = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            end
            do_reset(mm);
            for (int c = 0; c < 300; c++) begin
                int r;
                logic [5:0] btns;
                r = $urandom_range(0, 15);
                if (r < 6) btns = 6'd1 << r;
                else if (r < 8) btns = 6'($urandom);
                else btns = B_NONE;
                cycle(btns, ($urandom_range(0, 199) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
